fpu_issue_ctrl: RTL

- Issue-side controller for `fpu_16bit`: initiates every operation the FPU responds to.
- Accepts half-precision operation requests on a valid/ready port, holds the operands stable, and pulses the FPU start/reset line.
- Waits for `done` (with timeout), then returns result, OFUF and compare flags on a valid/ready response port.
- Sits between the command source (sequencer or bus bridge) and the `fpu_16bit` instance.

---
 rtl/fpu_pkg.sv | 30 +++
 rtl/fpu_issue_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the half-precision FPU issue controller and its bench:
// opcodes, flag field widths and the one-hot controller state encoding.
package fpu_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 2;
    localparam int OFUF_W = 2;
    localparam int COMP_W = 3;

    localparam logic [OP_W-1:0] FPU_ADD = 2'd0;
    localparam logic [OP_W-1:0] FPU_SUB = 2'd1;
    localparam logic [OP_W-1:0] FPU_MUL = 2'd2;
    localparam logic [OP_W-1:0] FPU_DIV = 2'd3;

    // One-hot so that req_ready / fpu_start / rsp_valid are plain flop bits.
    localparam int ST_IDLE_BIT   = 0;
    localparam int ST_START_BIT  = 1;
    localparam int ST_SETTLE_BIT = 2;
    localparam int ST_BUSY_BIT   = 3;
    localparam int ST_RESP_BIT   = 4;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_SETTLE = 5'b00100,
        ST_BUSY   = 5'b01000,
        ST_RESP   = 5'b10000
    } fpu_ctrl_state_e;

endpackage

// File: rtl/fpu_issue_ctrl.sv
// Issue-side controller for fpu_16bit: accepts one request at a time, holds the
// operands, pulses the FPU start/reset line, waits for done (bounded by a
// timeout) and returns result/flags on a response port.
//
// Handshakes: a transfer happens on every rising edge where valid and ready are
// both high; rsp_valid, once raised, stays high with stable data until
// rsp_ready is seen, and req_ready is only high in IDLE.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [OP_W-1:0]       req_op,
    input  logic [DATA_W-1:0]     req_x,
    input  logic [DATA_W-1:0]     req_y,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_result,
    output logic [OFUF_W-1:0]     rsp_ofuf,
    output logic [COMP_W-1:0]     rsp_comp,
    output logic                  rsp_timeout,
    output logic [DATA_W-1:0]     fpu_x,
    output logic [DATA_W-1:0]     fpu_y,
    output logic [OP_W-1:0]       fpu_opcode,
    output logic                  fpu_start,
    input  logic                  fpu_done,
    input  logic [DATA_W-1:0]     fpu_result,
    input  logic [OFUF_W-1:0]     fpu_ofuf,
    input  logic [COMP_W-1:0]     fpu_comp,
    output logic [CNT_W-1:0]      ops_done,
    output fpu_ctrl_state_e       dbg_state
);

    // Counter holds "cycles since the start pulse"; wide enough for the limit.
    localparam int                TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    fpu_ctrl_state_e      r_state;
    fpu_ctrl_state_e      w_next_state;
    logic [DATA_W-1:0]    r_x;
    logic [DATA_W-1:0]    r_y;
    logic [OP_W-1:0]      r_op;
    logic [DATA_W-1:0]    r_result;
    logic [OFUF_W-1:0]    r_ofuf;
    logic [COMP_W-1:0]    r_comp;
    logic                 r_timeout;
    logic [TMO_W-1:0]     r_tmo_cnt;
    logic [CNT_W-1:0]     r_ops_done;
    logic                 w_tmo_hit;

    assign w_tmo_hit = (r_tmo_cnt == TMO_LIMIT);

    // Next-state logic; done is only honoured in BUSY and wins over timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (req_valid) w_next_state = ST_START;
            ST_START:  w_next_state = ST_SETTLE;
            ST_SETTLE: w_next_state = ST_BUSY;
            ST_BUSY:   if (fpu_done || w_tmo_hit) w_next_state = ST_RESP;
            ST_RESP:   if (rsp_ready) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Operand capture, timeout counter, response capture and completion count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x        <= '0;
            r_y        <= '0;
            r_op       <= '0;
            r_result   <= '0;
            r_ofuf     <= '0;
            r_comp     <= '0;
            r_timeout  <= 1'b0;
            r_tmo_cnt  <= '0;
            r_ops_done <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_x  <= req_x;
                        r_y  <= req_y;
                        r_op <= req_op;
                    end
                end
                ST_START: r_tmo_cnt <= TMO_W'(1);
                ST_SETTLE: r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                ST_BUSY: begin
                    r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    if (fpu_done) begin
                        r_result  <= fpu_result;
                        r_ofuf    <= fpu_ofuf;
                        r_comp    <= fpu_comp;
                        r_timeout <= 1'b0;
                    end else if (w_tmo_hit) begin
                        r_result  <= '0;
                        r_ofuf    <= '0;
                        r_comp    <= '0;
                        r_timeout <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) r_ops_done <= r_ops_done + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Every output is a flop bit or flop vector; no input reaches an output.
    assign req_ready   = r_state[ST_IDLE_BIT];
    assign fpu_start   = r_state[ST_START_BIT];
    assign rsp_valid   = r_state[ST_RESP_BIT];
    assign rsp_result  = r_result;
    assign rsp_ofuf    = r_ofuf;
    assign rsp_comp    = r_comp;
    assign rsp_timeout = r_timeout;
    assign fpu_x       = r_x;
    assign fpu_y       = r_y;
    assign fpu_opcode  = r_op;
    assign ops_done    = r_ops_done;
    assign dbg_state   = r_state;

endmodule
